// File: rtl/news_pkg.sv
// Shared types and constants for the newspaper vending arbiter.
// Holds coin codes, arbiter FSM states, prices and an index helper.
package news_pkg;

    typedef enum logic [2:0] {
        COIN_NONE   = 3'd0,
        COIN_NICKEL = 3'd1,
        COIN_DIME   = 3'd2
    } coin_t;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DISPENSE,
        RELEASE
    } state_t;

    localparam logic [4:0] PRICE      = 5'd15;
    localparam logic [4:0] NICKEL_VAL = 5'd5;
    localparam logic [4:0] DIME_VAL   = 5'd10;

    // Index of the set bit of a one-hot vector (up to 8 ports).
    function automatic logic [2:0] onehot_index(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/news_rr_pick.sv
// Combinational round-robin picker: first requester at or after pointer.
// Ports: req, pointer in; grant (one-hot), valid out.
module news_rr_pick #(
    parameter int NPORT = 4
) (
    input  logic [NPORT-1:0] req,
    input  logic [2:0]       pointer,
    output logic [NPORT-1:0] grant,
    output logic             valid
);

    logic [3:0]       back;
    logic [NPORT-1:0] rot;
    logic [NPORT-1:0] low;

    assign back = 4'(NPORT) - {1'b0, pointer};

    // Rotate so the pointer port sits at bit 0, isolate the lowest
    // set bit, then rotate back.
    assign rot   = (req >> pointer) | (req << back);
    assign low   = rot & (-rot);
    assign grant = (low << pointer) | (low >> back);
    assign valid = |req;

endmodule

// File: rtl/news_arbiter.sv
// Arbitrates NPORT coin ports onto one vending core, tracks credit,
// handles dispense, timeouts, refunds and stuck-dispense faults.
// Ports: clock, reset, req, coin_in in; gnt, core_coin, core_abort,
// done, change_out, refund, refund_amt, bad_coin, fault out;
// core_newspaper, core_change in.
module news_arbiter
    import news_pkg::*;
#(
    parameter int NPORT   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NPORT-1:0]   req,
    input  logic [3*NPORT-1:0] coin_in,
    output logic [NPORT-1:0]   gnt,
    output logic [2:0]         core_coin,
    input  logic               core_newspaper,
    input  logic               core_change,
    output logic               core_abort,
    output logic [NPORT-1:0]   done,
    output logic [NPORT-1:0]   change_out,
    output logic [NPORT-1:0]   refund,
    output logic [3:0]         refund_amt,
    output logic               bad_coin,
    output logic               fault
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t           state;
    logic [NPORT-1:0] gnt_r;
    logic [2:0]       g_idx;
    logic [2:0]       ptr;
    logic [4:0]       credit;
    logic [CW-1:0]    idle_cnt;
    logic             dcnt;

    logic [NPORT-1:0] pick_gnt;
    logic             pick_valid;
    logic [2:0]       gcoin;
    logic             req_g;
    logic             is_nickel;
    logic             is_dime;
    logic             coin_ok;
    logic [4:0]       sum;
    logic             go_disp;
    logic             abort_a;
    logic             abort_d;

    news_rr_pick #(.NPORT(NPORT)) u_pick (
        .req     (req),
        .pointer (ptr),
        .grant   (pick_gnt),
        .valid   (pick_valid)
    );

    always_comb begin
        gcoin = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (gnt_r[p]) gcoin = coin_in[3*p +: 3];
        end
    end

    assign req_g     = |(req & gnt_r);
    assign is_nickel = (gcoin == COIN_NICKEL);
    assign is_dime   = (gcoin == COIN_DIME);
    assign coin_ok   = (state == ACTIVE) && (is_nickel || is_dime);
    assign bad_coin  = (state == ACTIVE) && !is_nickel && !is_dime
                       && (gcoin != COIN_NONE);
    assign core_coin = coin_ok ? gcoin : 3'd0;

    assign sum = credit + (is_dime ? DIME_VAL : NICKEL_VAL);

    // Paying in full wins over any timeout or request drop this cycle.
    assign go_disp = coin_ok && (sum >= PRICE);

    assign abort_a = (state == ACTIVE) && !go_disp
                     && (!req_g || (!coin_ok
                         && idle_cnt == CW'(TIMEOUT - 1)));

    assign abort_d = (state == DISPENSE) && !core_newspaper && dcnt;

    assign core_abort = abort_a || abort_d;
    assign refund     = (abort_a && credit != 5'd0) ? gnt_r : '0;
    assign refund_amt = (abort_a && credit != 5'd0) ? credit[3:0] : 4'd0;

    assign done = (state == DISPENSE && core_newspaper) ? gnt_r : '0;
    assign change_out = (state == DISPENSE && core_newspaper
                         && core_change) ? gnt_r : '0;

    assign gnt = gnt_r;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            gnt_r    <= '0;
            g_idx    <= '0;
            ptr      <= '0;
            credit   <= '0;
            idle_cnt <= '0;
            dcnt     <= 1'b0;
            fault    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state    <= ACTIVE;
                        gnt_r    <= pick_gnt;
                        g_idx    <= onehot_index(8'(pick_gnt));
                        credit   <= '0;
                        idle_cnt <= '0;
                    end
                end
                ACTIVE: begin
                    if (go_disp) begin
                        state  <= DISPENSE;
                        credit <= sum;
                        dcnt   <= 1'b0;
                    end else if (abort_a) begin
                        state <= RELEASE;
                        gnt_r <= '0;
                    end else if (coin_ok) begin
                        credit   <= sum;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + CW'(1);
                    end
                end
                DISPENSE: begin
                    if (core_newspaper) begin
                        state <= RELEASE;
                        gnt_r <= '0;
                    end else if (dcnt) begin
                        state <= RELEASE;
                        gnt_r <= '0;
                        fault <= 1'b1;
                    end else begin
                        dcnt <= 1'b1;
                    end
                end
                RELEASE: begin
                    state    <= IDLE;
                    credit   <= '0;
                    idle_cnt <= '0;
                    ptr      <= (g_idx == 3'(NPORT - 1)) ? 3'd0
                                                         : g_idx + 3'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_news_arbiter.sv
// Directed self-checking bench for news_arbiter (NPORT=4, TIMEOUT=16).
// Each task drives one scenario and checks outputs on the falling edge.
module tb_news_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [11:0] coin_in;
    logic [3:0]  gnt;
    logic [2:0]  core_coin;
    logic        core_newspaper;
    logic        core_change;
    logic        core_abort;
    logic [3:0]  done;
    logic [3:0]  change_out;
    logic [3:0]  refund;
    logic [3:0]  refund_amt;
    logic        bad_coin;
    logic        fault;

    int n_cmp = 0;
    int n_bad = 0;

    news_arbiter #(.NPORT(4), .TIMEOUT(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .req            (req),
        .coin_in        (coin_in),
        .gnt            (gnt),
        .core_coin      (core_coin),
        .core_newspaper (core_newspaper),
        .core_change    (core_change),
        .core_abort     (core_abort),
        .done           (done),
        .change_out     (change_out),
        .refund         (refund),
        .refund_amt     (refund_amt),
        .bad_coin       (bad_coin),
        .fault          (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_coin(input int p, input logic [2:0] c);
        coin_in = '0;
        coin_in[3*p +: 3] = c;
    endtask

    task automatic do_reset;
        req = '0;
        coin_in = '0;
        core_newspaper = 1'b0;
        core_change = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        n_cmp++;
        if (gnt !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_gnt: got %b want 0000", gnt);
        end
        n_cmp++;
        if ({core_coin, core_abort, bad_coin, fault} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_ctl: got %b want 000000",
                     {core_coin, core_abort, bad_coin, fault});
        end
        n_cmp++;
        if ({done, change_out, refund, refund_amt} !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_pulses: got %h want 0000",
                     {done, change_out, refund, refund_amt});
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_basic;
        do_reset();
        req = 4'b0001;
        @(negedge clock);
        n_cmp++;
        if (gnt !== 4'b0000) begin
            n_bad++;
            $display("FAIL basic_idle_gnt: got %b want 0000", gnt);
        end
        tick();
        set_coin(0, 3'd2);
        set_coin(0, 3'd2);
        coin_in[5:3] = 3'd1;
        @(negedge clock);
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_bad++;
            $display("FAIL basic_gnt: got %b want 0001", gnt);
        end
        n_cmp++;
        if (core_coin !== 3'd2) begin
            n_bad++;
            $display("FAIL basic_dime_fwd: got %0d want 2", core_coin);
        end
        tick();
        set_coin(0, 3'd1);
        @(negedge clock);
        n_cmp++;
        if (core_coin !== 3'd1) begin
            n_bad++;
            $display("FAIL basic_nickel_fwd: got %0d want 1", core_coin);
        end
        tick();
        coin_in = '0;
        core_newspaper = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (done !== 4'b0001 || change_out !== 4'b0000) begin
            n_bad++;
            $display("FAIL basic_done: got done=%b chg=%b want 0001/0000",
                     done, change_out);
        end
        tick();
        core_newspaper = 1'b0;
        req = 4'b1111;
        @(negedge clock);
        n_cmp++;
        if (gnt !== 4'b0000 || done !== 4'b0000) begin
            n_bad++;
            $display("FAIL basic_release: got gnt=%b done=%b want 0/0",
                     gnt, done);
        end
        tick();
        tick();
        @(negedge clock);
        n_cmp++;
        if (gnt !== 4'b0010) begin
            n_bad++;
            $display("FAIL basic_pointer: got %b want 0010", gnt);
        end
        tick();
        req = 4'b0000;
        @(negedge clock);
        n_cmp++;
        if (core_abort !== 1'b1 || refund !== 4'b0000) begin
            n_bad++;
            $display("FAIL basic_drop_abort: got abort=%b ref=%b want 1/0000",
                     core_abort, refund);
        end
        tick();
        tick();
    endtask

    task automatic test_round_robin;
        do_reset();
        req = 4'b0101;
        tick();
        @(negedge clock);
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_bad++;
            $display("FAIL rr_first: got %b want 0001", gnt);
        end
        for (int k = 0; k < 3; k++) begin
            coin_in = 12'b000_001_000_001;
            tick();
        end
        coin_in = '0;
        core_newspaper = 1'b1;
        core_change = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (done !== 4'b0001 || change_out !== 4'b0001) begin
            n_bad++;
            $display("FAIL rr_done0: got done=%b chg=%b want 0001/0001",
                     done, change_out);
        end
        tick();
        core_newspaper = 1'b0;
        core_change = 1'b0;
        tick();
        tick();
        @(negedge clock);
        n_cmp++;
        if (gnt !== 4'b0100) begin
            n_bad++;
            $display("FAIL rr_second: got %b want 0100", gnt);
        end
        for (int k = 0; k < 3; k++) begin
            set_coin(2, 3'd1);
            tick();
        end
        coin_in = '0;
        core_newspaper = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (done !== 4'b0100 || change_out !== 4'b0000) begin
            n_bad++;
            $display("FAIL rr_done2: got done=%b chg=%b want 0100/0000",
                     done, change_out);
        end
        tick();
        core_newspaper = 1'b0;
        req = '0;
        tick();
    endtask

    task automatic test_timeout;
        do_reset();
        req = 4'b0010;
        tick();
        set_coin(1, 3'd1);
        tick();
        coin_in = '0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            n_cmp++;
            if (core_abort !== 1'b0 || refund !== 4'b0000) begin
                n_bad++;
                $display("FAIL timeout_early_%0d: got abort=%b ref=%b want 0",
                         i, core_abort, refund);
            end
            tick();
        end
        @(negedge clock);
        n_cmp++;
        if (refund !== 4'b0010 || refund_amt !== 4'd5) begin
            n_bad++;
            $display("FAIL timeout_refund: got ref=%b amt=%0d want 0010/5",
                     refund, refund_amt);
        end
        n_cmp++;
        if (core_abort !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_abort: got %b want 1", core_abort);
        end
        tick();
        @(negedge clock);
        n_cmp++;
        if (gnt !== 4'b0000 || refund_amt !== 4'd0) begin
            n_bad++;
            $display("FAIL timeout_release: got gnt=%b amt=%0d want 0/0",
                     gnt, refund_amt);
        end
        req = '0;
        tick();
    endtask

    task automatic test_bad_coin;
        do_reset();
        req = 4'b0001;
        tick();
        set_coin(0, 3'd5);
        coin_in[5:3] = 3'd2;
        @(negedge clock);
        n_cmp++;
        if (core_coin !== 3'd0 || bad_coin !== 1'b1) begin
            n_bad++;
            $display("FAIL bad_coin: got coin=%0d bad=%b want 0/1",
                     core_coin, bad_coin);
        end
        tick();
        set_coin(0, 3'd1);
        @(negedge clock);
        n_cmp++;
        if (core_coin !== 3'd1 || bad_coin !== 1'b0) begin
            n_bad++;
            $display("FAIL bad_then_good: got coin=%0d bad=%b want 1/0",
                     core_coin, bad_coin);
        end
        tick();
        coin_in = '0;
        req = '0;
        @(negedge clock);
        n_cmp++;
        if (refund !== 4'b0001 || refund_amt !== 4'd5
            || core_abort !== 1'b1) begin
            n_bad++;
            $display("FAIL bad_credit: got ref=%b amt=%0d ab=%b want 0001/5/1",
                     refund, refund_amt, core_abort);
        end
        tick();
        tick();
    endtask

    task automatic test_fault;
        do_reset();
        req = 4'b1000;
        tick();
        @(negedge clock);
        n_cmp++;
        if (gnt !== 4'b1000) begin
            n_bad++;
            $display("FAIL fault_gnt: got %b want 1000", gnt);
        end
        set_coin(3, 3'd2);
        tick();
        set_coin(3, 3'd2);
        tick();
        coin_in = '0;
        @(negedge clock);
        n_cmp++;
        if (fault !== 1'b0 || core_abort !== 1'b0) begin
            n_bad++;
            $display("FAIL fault_wait0: got f=%b ab=%b want 0/0",
                     fault, core_abort);
        end
        tick();
        @(negedge clock);
        n_cmp++;
        if (fault !== 1'b0 || core_abort !== 1'b1) begin
            n_bad++;
            $display("FAIL fault_wait1: got f=%b ab=%b want 0/1",
                     fault, core_abort);
        end
        tick();
        @(negedge clock);
        n_cmp++;
        if (fault !== 1'b1 || gnt !== 4'b0000 || done !== 4'b0000) begin
            n_bad++;
            $display("FAIL fault_set: got f=%b gnt=%b done=%b want 1/0/0",
                     fault, gnt, done);
        end
        req = '0;
        tick();
        @(negedge clock);
        n_cmp++;
        if (fault !== 1'b1) begin
            n_bad++;
            $display("FAIL fault_sticky: got %b want 1", fault);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        req = 4'b0001;
        tick();
        set_coin(0, 3'd2);
        tick();
        set_coin(0, 3'd1);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (gnt !== 4'b0000 || core_coin !== 3'd0) begin
            n_bad++;
            $display("FAIL rstmid_gnt: got gnt=%b coin=%0d want 0/0",
                     gnt, core_coin);
        end
        n_cmp++;
        if ({refund, refund_amt, core_abort, fault, done} !== 13'h0) begin
            n_bad++;
            $display("FAIL rstmid_outs: got %h want 0",
                     {refund, refund_amt, core_abort, fault, done});
        end
        req = '0;
        coin_in = '0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_cmp++;
            if (refund !== 4'b0000 || core_abort !== 1'b0) begin
                n_bad++;
                $display("FAIL rstmid_norefund_%0d: got ref=%b ab=%b want 0",
                         i, refund, core_abort);
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        req = '0;
        coin_in = '0;
        core_newspaper = 1'b0;
        core_change = 1'b0;
        test_reset();
        test_basic();
        test_round_robin();
        test_timeout();
        test_bad_coin();
        test_fault();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/news_arbiter.md
NEWS_ARBITER -- requirements
Module: news_arbiter

Interface
REQ-001 The block SHALL have parameter NPORT, default 4, giving the number of customer coin ports (2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 16, giving the idle cycles allowed in a session before abort.
REQ-003 The block SHALL have port clock  in  1  clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port req  in  NPORT  per-port session request, level.
REQ-006 The block SHALL have port coin_in  in  3*NPORT  per-port coin code; port p uses bits 3p+2:3p; 0 none, 1 nickel, 2 dime, 3-7 invalid.
REQ-007 The block SHALL have port gnt  out  NPORT  one-hot session grant.
REQ-008 The block SHALL have port core_coin  out  3  coin code forwarded to the vending core.
REQ-009 The block SHALL have ports core_newspaper and core_change  in  1 each  vending core outputs.
REQ-010 The block SHALL have port core_abort  out  1  one-cycle pulse that clears the vending core to zero credit.
REQ-011 The block SHALL have ports done, change_out and refund  out  NPORT each  one-cycle per-port pulses.
REQ-012 The block SHALL have ports refund_amt  out  4  refunded credit in cents; bad_coin  out  1  pulse; fault  out  1  sticky.

Function
REQ-013 The FSM SHALL have states IDLE, ACTIVE, DISPENSE, RELEASE.
REQ-014 In IDLE with any req set, the block SHALL pick the first requester at or after the round-robin pointer and enter ACTIVE the next cycle with the matching gnt bit set.
REQ-015 In ACTIVE, core_coin SHALL combinationally equal the granted port's coin when it is 1 or 2, and SHALL be 0 otherwise and in every other state.
REQ-016 An invalid code (3-7) on the granted port SHALL be forwarded as 0 and pulse bad_coin in the same cycle; coins on non-granted ports SHALL be ignored.
REQ-017 Internal credit (0, 5, 10) SHALL add 5 per nickel and 10 per dime; a coin that brings credit to 15 or more SHALL move the FSM to DISPENSE.
REQ-018 In DISPENSE, when core_newspaper is 1, the block SHALL pulse done[granted] and, if core_change is 1, change_out[granted] in the same cycle, then enter RELEASE.
REQ-019 If core_newspaper is not seen within 2 cycles of entering DISPENSE, the block SHALL set fault, pulse core_abort and enter RELEASE.
REQ-020 The ACTIVE idle counter SHALL clear on every valid coin; reaching TIMEOUT cycles, or req[granted] falling, SHALL abort the session.
REQ-021 On abort with credit > 0, the block SHALL pulse refund[granted] with refund_amt equal to the credit and pulse core_abort; with credit 0, only core_abort SHALL pulse.
REQ-022 In RELEASE, gnt SHALL be all zero, credit SHALL clear, and the pointer SHALL become granted+1 modulo NPORT; the next state SHALL be IDLE.
REQ-023 refund_amt SHALL be 0 whenever refund is not pulsing.
REQ-024 A DISPENSE entry on the same cycle as a timeout SHALL take priority over the timeout.

Reset
REQ-025 Reset SHALL force IDLE, pointer 0, credit 0, idle counter 0, and fault 0.
REQ-026 Reset SHALL force all outputs to 0, including mid-session; no refund SHALL be issued for credit lost to reset.

Structure
REQ-027 Package news_pkg SHALL hold the coin code enum, the FSM state typedef, and the constants PRICE=15, NICKEL_VAL=5, and DIME_VAL=10.
REQ-028 The round-robin selection SHALL be a combinational sub-module news_rr_pick with inputs req and pointer and outputs a one-hot grant and a valid flag.

Verification
REQ-029 With req=0001, port0 coins dime then nickel, and core_newspaper=1 on cycle 3, the bench SHALL see gnt=0001, done[0] pulse, change_out=0, and pointer=1.
REQ-030 With req=0101 held and both sessions each paying nickel, nickel, nickel, the bench SHALL see port0 granted first and then port2.
REQ-031 With port1 paying a nickel then staying idle for 16 cycles, the bench SHALL see refund[1] pulse, refund_amt=5, and core_abort pulse.
REQ-032 With port0 coin=5 in ACTIVE, the bench SHALL see core_coin=0, a bad_coin pulse, and credit unchanged.
REQ-033 With port3 paying dime, dime and core_newspaper held at 0, the bench SHALL see fault=1 two cycles after entering DISPENSE and a core_abort pulse.
REQ-034 With reset asserted mid-ACTIVE at credit 10, the bench SHALL see gnt=0, outputs 0 immediately, and no refund pulse.
